// File: rtl/tile_ram_arbiter_if.sv
// rtl/tile_ram_arbiter_if.sv - bus bundle between the tile RAM arbiter, its clients and the tile RAM
//
// Groups the three client ports and the RAM command/response port.
//   video  : vid_req/vid_addr in, vid_data/vid_valid out
//   game   : gm_req/gm_we/gm_addr/gm_wdata in, gm_gnt/gm_rdata/gm_rvalid out
//   clear  : clr_start in, clr_busy/clr_done out; err_starve out
//   ram    : ram_addr/ram_we/ram_wdata out (registered), ram_rdata in (1-cycle latency)
// slave  = arbiter view, master = environment (clients + RAM) view.
interface tile_ram_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 4
);
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic [DATA_W-1:0] vid_data;
  logic              vid_valid;
  logic              gm_req;
  logic              gm_we;
  logic [ADDR_W-1:0] gm_addr;
  logic [DATA_W-1:0] gm_wdata;
  logic              gm_gnt;
  logic [DATA_W-1:0] gm_rdata;
  logic              gm_rvalid;
  logic              clr_start;
  logic              clr_busy;
  logic              clr_done;
  logic              err_starve;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  vid_req, vid_addr, gm_req, gm_we, gm_addr, gm_wdata, clr_start, ram_rdata,
    output vid_data, vid_valid, gm_gnt, gm_rdata, gm_rvalid, clr_busy, clr_done,
           err_starve, ram_addr, ram_we, ram_wdata
  );

  modport master (
    output vid_req, vid_addr, gm_req, gm_we, gm_addr, gm_wdata, clr_start, ram_rdata,
    input  vid_data, vid_valid, gm_gnt, gm_rdata, gm_rvalid, clr_busy, clr_done,
           err_starve, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/tile_ram_arbiter.sv
// rtl/tile_ram_arbiter.sv - shares one single-port tile RAM between video, bulk clear and game logic
//
// Priority per cycle: video read > clear write > game access. One RAM command per cycle.
// Ports:
//   clk    system clock
//   reset  asynchronous active-low reset
//   bus    tile_ram_arbiter_if.slave (video, game, clear, status and RAM signals)
// Read timing: request accepted in cycle t, ram_* driven in t+1, ram_rdata in t+2,
// vid_valid/gm_rvalid with data in t+3. Game writes reach the RAM in t+1 with no response.
module tile_ram_arbiter #(
  parameter int                ADDR_W       = 13,
  parameter int                DATA_W       = 4,
  parameter int                DEPTH        = 4800,
  parameter logic [DATA_W-1:0] CLR_DATA     = DATA_W'(1),
  parameter int                STARVE_LIMIT = 32
) (
  input logic               clk,
  input logic               reset,
  tile_ram_arbiter_if.slave bus
);

  localparam logic [ADDR_W-1:0] CLR_LAST   = ADDR_W'(DEPTH - 1);
  localparam int                WAIT_W     = $clog2(STARVE_LIMIT + 2);
  localparam logic [WAIT_W-1:0] WAIT_MAX   = '1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_addr;
  // Read tags: bit 0 = video, bit 1 = game. tag_cmd travels with the RAM
  // command, tag_dat lines up with ram_rdata one cycle later.
  logic [1:0]        tag_cmd;
  logic [1:0]        tag_dat;
  logic [WAIT_W-1:0] wait_cnt;

  logic [ADDR_W-1:0] ram_addr_q;
  logic              ram_we_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic [DATA_W-1:0] vid_data_q;
  logic              vid_valid_q;
  logic [DATA_W-1:0] gm_rdata_q;
  logic              gm_rvalid_q;
  logic              err_starve_q;
  logic              clr_busy;
  logic              gm_gnt;

  assign clr_busy = (state == CLEAR);
  // Gated by reset so the grant reads 0 while the block is held in reset.
  assign gm_gnt   = reset & bus.gm_req & ~bus.vid_req & ~clr_busy;

  assign bus.gm_gnt     = gm_gnt;
  assign bus.clr_busy   = clr_busy;
  assign bus.clr_done   = (state == DONE);
  assign bus.err_starve = err_starve_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.ram_wdata  = ram_wdata_q;
  assign bus.vid_data   = vid_data_q;
  assign bus.vid_valid  = vid_valid_q;
  assign bus.gm_rdata   = gm_rdata_q;
  assign bus.gm_rvalid  = gm_rvalid_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      clr_addr     <= '0;
      tag_cmd      <= 2'b00;
      tag_dat      <= 2'b00;
      wait_cnt     <= '0;
      ram_addr_q   <= '0;
      ram_we_q     <= 1'b0;
      ram_wdata_q  <= '0;
      vid_data_q   <= '0;
      vid_valid_q  <= 1'b0;
      gm_rdata_q   <= '0;
      gm_rvalid_q  <= 1'b0;
      err_starve_q <= 1'b0;
    end else begin
      // Command issue: exactly one source owns the RAM this cycle.
      tag_cmd  <= 2'b00;
      ram_we_q <= 1'b0;
      if (bus.vid_req) begin
        ram_addr_q <= bus.vid_addr;
        tag_cmd    <= 2'b01;
      end else if (state == CLEAR) begin
        ram_addr_q  <= clr_addr;
        ram_we_q    <= 1'b1;
        ram_wdata_q <= CLR_DATA;
      end else if (bus.gm_req) begin
        ram_addr_q  <= bus.gm_addr;
        ram_we_q    <= bus.gm_we;
        ram_wdata_q <= bus.gm_wdata;
        tag_cmd     <= {~bus.gm_we, 1'b0};
      end

      // Clear sequencer: the counter only advances on cycles it actually wrote.
      case (state)
        IDLE: begin
          if (bus.clr_start) begin
            state    <= CLEAR;
            clr_addr <= '0;
          end
        end
        CLEAR: begin
          if (!bus.vid_req) begin
            if (clr_addr == CLR_LAST) begin
              state    <= DONE;
              clr_addr <= '0;
            end else begin
              clr_addr <= clr_addr + 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // Response steering: the tag that rode with the command picks the port.
      tag_dat     <= tag_cmd;
      vid_valid_q <= tag_dat[0];
      gm_rvalid_q <= tag_dat[1];
      if (tag_dat[0]) vid_data_q <= bus.ram_rdata;
      if (tag_dat[1]) gm_rdata_q <= bus.ram_rdata;

      // Starvation watch: flag once the wait goes past STARVE_LIMIT cycles.
      if (bus.gm_req && !gm_gnt) begin
        if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
        if (wait_cnt >= WAIT_LIMIT) err_starve_q <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tile_ram_arbiter.sv
// tb/tb_tile_ram_arbiter.sv - scoreboard bench for tile_ram_arbiter with a 1-cycle RAM model
module tb_tile_ram_arbiter;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 4;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  int unsigned cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tile_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  tile_ram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(4800), .CLR_DATA(4'h1), .STARVE_LIMIT(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  typedef struct packed {
    logic [DATA_W-1:0] data;
    int unsigned       cyc;
  } exp_t;

  exp_t vq[$];
  exp_t gq[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_pass   = 0;
  int vid_seen = 0, gm_seen = 0, stray = 0;
  int we_cnt = 0, done_cnt = 0;
  int clr_writes = 0, clr_bad = 0;
  bit clr_watch = 1'b0;
  logic [ADDR_W-1:0] clr_next = '0;
  bit granted, hit;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic exp_t mk(input logic [DATA_W-1:0] d, input int unsigned c);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    return e;
  endfunction

  // Monitor: pops the scoreboard whenever a response appears.
  always @(negedge clk) begin
    if (bus.vid_valid) begin
      vid_seen++;
      if (vq.size() == 0) stray++;
      else begin
        mon_e = vq.pop_front();
        chk("vid_data", 32'(bus.vid_data), 32'(mon_e.data));
        chk("vid_cycle", cyc, mon_e.cyc);
      end
    end
    if (bus.gm_rvalid) begin
      gm_seen++;
      if (gq.size() == 0) stray++;
      else begin
        mon_e = gq.pop_front();
        chk("gm_rdata", 32'(bus.gm_rdata), 32'(mon_e.data));
        chk("gm_cycle", cyc, mon_e.cyc);
      end
    end
    if (bus.ram_we) begin
      we_cnt++;
      if (clr_watch) begin
        clr_writes++;
        if (bus.ram_addr != clr_next || bus.ram_wdata != 4'h1) clr_bad++;
        clr_next++;
      end
    end
    if (bus.clr_done) done_cnt++;
  end

  task automatic vid_issue(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] exp_d);
    bus.vid_req  = 1'b1;
    bus.vid_addr = addr;
    vq.push_back(mk(exp_d, cyc + 3));
  endtask

  // Called at a negedge; returns at a negedge with gm_req dropped.
  task automatic gm_op(input logic we, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] exp_rd);
    bit got = 1'b0;
    bus.gm_req = 1'b1; bus.gm_we = we; bus.gm_addr = addr; bus.gm_wdata = wd;
    for (int i = 0; i < 200 && !got; i++) begin
      #1;
      if (bus.gm_gnt) begin
        got = 1'b1;
        if (!we) gq.push_back(mk(exp_rd, cyc + 3));
      end
      @(negedge clk);
    end
    bus.gm_req = 1'b0;
    chk("gm_grant_wait", 32'(got), 32'd1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // T1: reset held with requests active, then an in-flight read killed by reset
    bus.vid_req = 1'b1; bus.vid_addr = '0; bus.gm_req = 1'b1; bus.gm_we = 1'b0;
    bus.gm_addr = '0; bus.gm_wdata = '0; bus.clr_start = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs_zero",
        {bus.vid_valid, bus.vid_data, bus.gm_gnt, bus.gm_rdata, bus.gm_rvalid, bus.clr_busy,
         bus.clr_done, bus.err_starve, bus.ram_addr, bus.ram_we, bus.ram_wdata}, 32'd0);
    @(negedge clk); reset = 1'b1; bus.vid_addr = 13'h123;
    @(negedge clk); reset = 1'b0; bus.vid_req = 1'b0; bus.gm_req = 1'b0;
    @(negedge clk); reset = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk("reset_no_vid_valid", vid_seen, 0);
    chk("reset_no_gm_rvalid", gm_seen, 0);
    @(negedge clk);

    // Preload through the game port
    gm_op(1'b1, 13'h123, 4'h7, 4'h0);
    gm_op(1'b1, 13'h005, 4'h3, 4'h0);
    gm_op(1'b1, 13'h009, 4'hA, 4'h0);
    gm_op(1'b1, 13'h1FFF, 4'h5, 4'h0);

    // T2: single video read
    vid_issue(13'h123, 4'h7);
    @(negedge clk); bus.vid_req = 1'b0; #1;
    chk("t2_ram_addr", 32'(bus.ram_addr), 32'h123);
    chk("t2_ram_we", 32'(bus.ram_we), 32'd0);
    repeat (4) @(negedge clk);

    // T3: video and game read collide
    vid_issue(13'h005, 4'h3);
    bus.gm_req = 1'b1; bus.gm_we = 1'b0; bus.gm_addr = 13'h009; #1;
    chk("t3_gnt_blocked", 32'(bus.gm_gnt), 32'd0);
    @(negedge clk); bus.vid_req = 1'b0; #1;
    chk("t3_gnt_next", 32'(bus.gm_gnt), 32'd1);
    gq.push_back(mk(4'hA, cyc + 3));
    @(negedge clk); bus.gm_req = 1'b0;
    repeat (5) @(negedge clk);

    // T4: game write then read back
    we_cnt = 0;
    gm_op(1'b1, 13'h040, 4'h2, 4'h0);
    repeat (3) @(negedge clk);
    #1;
    chk("t4_we_one_cycle", we_cnt, 1);
    @(negedge clk);
    gm_op(1'b0, 13'h040, 4'h0, 4'h2);
    repeat (5) @(negedge clk);

    // T5: bulk clear with video every second cycle and a waiting game read
    clr_watch = 1'b1; clr_next = '0; clr_writes = 0; clr_bad = 0; done_cnt = 0;
    bus.clr_start = 1'b1;
    @(negedge clk);
    bus.clr_start = 1'b0;
    bus.gm_req = 1'b1; bus.gm_we = 1'b0; bus.gm_addr = 13'h010;
    granted = 1'b0;
    for (int i = 0; i < 12000 && !granted; i++) begin
      bus.vid_req = (i % 2 == 0);
      if (i % 2 == 0) vid_issue(13'h1FFF, 4'h5);
      bus.clr_start = (i == 2000);
      #1;
      if (i == 0) chk("t5_busy", 32'(bus.clr_busy), 32'd1);
      if (bus.gm_gnt) begin
        granted = 1'b1;
        gq.push_back(mk(4'h1, cyc + 3));
        chk("t5_gnt_after_sweep", clr_writes, 4800);
      end
      @(negedge clk);
    end
    bus.gm_req = 1'b0; bus.vid_req = 1'b0; bus.clr_start = 1'b0;
    chk("t5_granted", 32'(granted), 32'd1);
    repeat (10) @(negedge clk);
    #1;
    clr_watch = 1'b0;
    chk("t5_writes", clr_writes, 4800);
    chk("t5_no_gaps", clr_bad, 0);
    chk("t5_done_once", done_cnt, 1);
    chk("t5_idle", 32'(bus.clr_busy), 32'd0);
    chk("t5_starved", 32'(bus.err_starve), 32'd1);

    // T6a: reset in the middle of a sweep
    @(negedge clk);
    done_cnt = 0;
    bus.clr_start = 1'b1;
    @(negedge clk); bus.clr_start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clk); #1;
      if (bus.ram_we && bus.ram_addr == 13'd99) hit = 1'b1;
    end
    chk("t6_reached_100", 32'(hit), 32'd1);
    reset = 1'b0; #1;
    chk("t6_busy_cleared", 32'(bus.clr_busy), 32'd0);
    chk("t6_starve_cleared", 32'(bus.err_starve), 32'd0);
    @(negedge clk); reset = 1'b1; we_cnt = 0;
    repeat (10) @(negedge clk);
    #1;
    chk("t6_no_done", done_cnt, 0);
    chk("t6_no_writes", we_cnt, 0);
    chk("t6_idle", 32'(bus.clr_busy), 32'd0);

    // T6b: game starved by 40 cycles of video
    @(negedge clk);
    bus.gm_req = 1'b1; bus.gm_we = 1'b0; bus.gm_addr = 13'h010;
    for (int k = 1; k <= 40; k++) begin
      vid_issue(13'h1FFF, 4'h5);
      #1;
      if (k == 33) chk("t6_starve_not_yet", 32'(bus.err_starve), 32'd0);
      if (k == 34) chk("t6_starve_set", 32'(bus.err_starve), 32'd1);
      @(negedge clk);
    end
    bus.vid_req = 1'b0;
    gm_op(1'b0, 13'h010, 4'h0, 4'h1);
    repeat (5) @(negedge clk);
    #1;
    chk("t6_starve_sticky", 32'(bus.err_starve), 32'd1);

    repeat (3) @(negedge clk);
    #1;
    chk("no_stray_valid", stray, 0);
    chk("vid_queue_drained", vq.size(), 0);
    chk("gm_queue_drained", gq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
